// File: rtl/irom_arbiter_pkg.sv
// Shared constants and types for the instruction-ROM arbiter slice.
// Widths mirror the core-wide instruction bus definitions.
package irom_arbiter_pkg;

    localparam int InstAddrBus   = 32;
    localparam int InstBus       = 32;
    localparam int InstMemNumLen = 17;

    localparam logic [InstBus-1:0] ZeroWord    = '0;
    localparam logic               ChipEnable  = 1'b1;
    localparam logic               ChipDisable = 1'b0;

    // Port identifiers, also the encoding of the round-robin pointer.
    localparam logic PortIf  = 1'b0;
    localparam logic PortDbg = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/irom_arbiter_if.sv
// Bundle of the two request/response ports, the IF flush and the ROM side.
// The arbiter uses the slave view; IF/PC, debug unit and ROM form the master view.
interface irom_arbiter_if
    import irom_arbiter_pkg::*;
#(
    parameter int ADDR_W = InstAddrBus,
    parameter int DATA_W = InstBus
) ();

    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [DATA_W-1:0] rsp0_data;
    logic              rsp0_err;
    logic              flush0;

    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp1_data;
    logic              rsp1_err;

    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_inst;

    modport slave (
        input  req0_valid, req0_addr, rsp0_ready, flush0,
        input  req1_valid, req1_addr, rsp1_ready,
        input  rom_inst,
        output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_data, rsp1_err,
        output rom_ce, rom_addr
    );

    modport master (
        output req0_valid, req0_addr, rsp0_ready, flush0,
        output req1_valid, req1_addr, rsp1_ready,
        output rom_inst,
        input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_data, rsp1_err,
        input  rom_ce, rom_addr
    );

endinterface

// File: rtl/irom_rsp_slot.sv
// One-entry registered response buffer: FULL flag plus data/err.
// Clear beats load beats drain; load while draining keeps the slot FULL with new data.
module irom_rsp_slot
    import irom_arbiter_pkg::*;
#(
    parameter int DATA_W = InstBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_drain,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_err,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_err
);

    slot_state_e       r_state;
    slot_state_e       w_state_next;
    logic [DATA_W-1:0] r_data;
    logic              r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_clear) begin
            w_state_next = SLOT_EMPTY;
        end else if (i_load) begin
            w_state_next = SLOT_FULL;
        end else if (i_drain) begin
            w_state_next = SLOT_EMPTY;
        end
    end

    // Payload only moves on a load, so it stays quiet while EMPTY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_err  <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_err  <= i_err;
        end
    end

    assign o_valid = (r_state == SLOT_FULL);
    assign o_data  = r_data;
    assign o_err   = r_err;

endmodule

// File: rtl/irom_arbiter.sv
// Round-robin arbiter sharing one combinational-read instruction ROM between
// the IF fetch port (0) and the debug/loader port (1), each with a response slot.
module irom_arbiter
    import irom_arbiter_pkg::*;
#(
    parameter int ADDR_W   = InstAddrBus,
    parameter int DATA_W   = InstBus,
    parameter int MEM_LOG2 = InstMemNumLen
) (
    input  logic            clk,
    input  logic            rst,
    irom_arbiter_if.slave   bus
);

    logic              r_last;
    logic [1:0]        w_req_valid;
    logic [1:0]        w_rsp_ready;
    logic [1:0]        w_rsp_valid;
    logic [1:0]        w_rsp_err;
    logic [1:0]        w_block;
    logic [1:0]        w_elig;
    logic [1:0]        w_gnt;
    logic [ADDR_W-1:0] w_req_addr [2];
    logic [DATA_W-1:0] w_rsp_data [2];
    logic [ADDR_W-1:0] w_gnt_addr;
    logic              w_mis;
    logic              w_oor;
    logic              w_legal;
    logic [DATA_W-1:0] w_load_data;

    assign w_req_valid   = {bus.req1_valid, bus.req0_valid};
    assign w_rsp_ready   = {bus.rsp1_ready, bus.rsp0_ready};
    assign w_req_addr[0] = bus.req0_addr;
    assign w_req_addr[1] = bus.req1_addr;
    // Flush both blocks the IF grant and empties the IF slot.
    assign w_block       = {1'b0, bus.flush0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            // Gating with rst keeps ready and the ROM quiet during reset.
            assign w_elig[gi] = rst && w_req_valid[gi] && !w_block[gi] &&
                                (!w_rsp_valid[gi] || w_rsp_ready[gi]);

            irom_rsp_slot #(.DATA_W(DATA_W)) u_slot (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_gnt[gi]),
                .i_drain (w_rsp_valid[gi] && w_rsp_ready[gi]),
                .i_clear (w_block[gi]),
                .i_data  (w_load_data),
                .i_err   (!w_legal),
                .o_valid (w_rsp_valid[gi]),
                .o_data  (w_rsp_data[gi]),
                .o_err   (w_rsp_err[gi])
            );
        end
    endgenerate

    always_comb begin
        w_gnt = w_elig;
        if (&w_elig) begin
            w_gnt = (r_last == PortDbg) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= PortDbg;
        end else if (w_gnt[0]) begin
            r_last <= PortIf;
        end else if (w_gnt[1]) begin
            r_last <= PortDbg;
        end
    end

    always_comb begin
        w_gnt_addr = '0;
        if (w_gnt[0]) begin
            w_gnt_addr = w_req_addr[0];
        end else if (w_gnt[1]) begin
            w_gnt_addr = w_req_addr[1];
        end
    end

    assign w_mis   = (w_gnt_addr[1:0] != 2'b00);
    assign w_oor   = ((w_gnt_addr >> (MEM_LOG2 + 2)) != '0);
    assign w_legal = (|w_gnt) && !w_mis && !w_oor;

    assign w_load_data = w_legal ? bus.rom_inst : DATA_W'(ZeroWord);

    assign bus.rom_ce   = w_legal ? ChipEnable : ChipDisable;
    assign bus.rom_addr = w_legal ? w_gnt_addr : '0;

    assign bus.req0_ready = w_gnt[0];
    assign bus.req1_ready = w_gnt[1];
    assign bus.rsp0_valid = w_rsp_valid[0];
    assign bus.rsp1_valid = w_rsp_valid[1];
    assign bus.rsp0_data  = w_rsp_data[0];
    assign bus.rsp1_data  = w_rsp_data[1];
    assign bus.rsp0_err   = w_rsp_err[0];
    assign bus.rsp1_err   = w_rsp_err[1];

endmodule

// File: tb/tb_irom_arbiter.sv
// Directed bench for irom_arbiter: reset, contention, streaming, backpressure,
// access errors and IF flush against a small ROM content model.
module tb_irom_arbiter;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    irom_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    irom_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LOG2(17)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h4) return 32'h3C01_0101;
        return {16'hC0DE, a[15:0]};
    endfunction

    always_comb bus.rom_inst = rom_word(bus.rom_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.rsp0_ready = 1'b1; bus.flush0 = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.rsp1_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 32'h4;
        #1;
        checks++; if (bus.rsp0_valid !== 1'b0) begin errors++; $display("FAIL rst_v0 got=%b exp=0", bus.rsp0_valid); end
        checks++; if (bus.rsp1_valid !== 1'b0) begin errors++; $display("FAIL rst_v1 got=%b exp=0", bus.rsp1_valid); end
        checks++; if (bus.rsp0_data !== 32'h0) begin errors++; $display("FAIL rst_d0 got=%h exp=0", bus.rsp0_data); end
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL rst_rdy0 got=%b exp=0", bus.req0_ready); end
        checks++; if (bus.rom_ce !== 1'b0) begin errors++; $display("FAIL rst_ce got=%b exp=0", bus.rom_ce); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL rel_rdy0 got=%b exp=1", bus.req0_ready); end
        checks++; if (bus.rom_addr !== 32'h4) begin errors++; $display("FAIL rel_addr got=%h exp=4", bus.rom_addr); end
        tick();
        bus.req0_valid = 1'b0;
        checks++; if (bus.rsp0_valid !== 1'b1) begin errors++; $display("FAIL first_v0 got=%b exp=1", bus.rsp0_valid); end
        checks++; if (bus.rsp0_data !== 32'h3C01_0101) begin errors++; $display("FAIL first_d0 got=%h exp=3c010101", bus.rsp0_data); end
        bus.rsp0_ready = 1'b0; bus.req0_valid = 1'b1; bus.req0_addr = 32'h8;
        rst = 1'b0;
        #1;
        checks++; if (bus.rsp0_valid !== 1'b0) begin errors++; $display("FAIL mid_v0 got=%b exp=0", bus.rsp0_valid); end
        checks++; if (bus.rsp0_data !== 32'h0) begin errors++; $display("FAIL mid_d0 got=%h exp=0", bus.rsp0_data); end
        checks++; if (bus.rom_ce !== 1'b0) begin errors++; $display("FAIL mid_ce got=%b exp=0", bus.rom_ce); end
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_contention();
        bus.req0_valid = 1'b1; bus.req0_addr = 32'h10;
        bus.req1_valid = 1'b1; bus.req1_addr = 32'h20;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.req0_ready !== (i % 2 == 0)) begin errors++; $display("FAIL cont_rdy0[%0d] got=%b exp=%b", i, bus.req0_ready, (i % 2 == 0)); end
            checks++; if (bus.req1_ready !== (i % 2 == 1)) begin errors++; $display("FAIL cont_rdy1[%0d] got=%b exp=%b", i, bus.req1_ready, (i % 2 == 1)); end
            tick();
            if (i % 2 == 0) begin
                checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 32'hC0DE_0010) begin errors++; $display("FAIL cont_rsp0[%0d] got=%b/%h exp=1/c0de0010", i, bus.rsp0_valid, bus.rsp0_data); end
            end else begin
                checks++; if (bus.rsp1_valid !== 1'b1 || bus.rsp1_data !== 32'hC0DE_0020) begin errors++; $display("FAIL cont_rsp1[%0d] got=%b/%h exp=1/c0de0020", i, bus.rsp1_valid, bus.rsp1_data); end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
        bus.req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req0_addr = addrs[i];
            #1;
            checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL b2b_rdy[%0d] got=%b exp=1", i, bus.req0_ready); end
            tick();
            checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== rom_word(addrs[i])) begin errors++; $display("FAIL b2b_rsp[%0d] got=%b/%h exp=1/%h", i, bus.rsp0_valid, bus.rsp0_data, rom_word(addrs[i])); end
        end
        idle_inputs();
        tick();
        checks++; if (bus.rsp0_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", bus.rsp0_valid); end
    endtask

    task automatic test_backpressure();
        bus.req1_valid = 1'b1; bus.req1_addr = 32'h30; bus.rsp1_ready = 1'b0;
        tick();
        bus.req1_addr = 32'h34; bus.req0_valid = 1'b1; bus.req0_addr = 32'h40;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL bp_rdy1[%0d] got=%b exp=0", i, bus.req1_ready); end
            checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy0[%0d] got=%b exp=1", i, bus.req0_ready); end
            tick();
            checks++; if (bus.rsp1_valid !== 1'b1 || bus.rsp1_data !== 32'hC0DE_0030) begin errors++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/c0de0030", i, bus.rsp1_valid, bus.rsp1_data); end
            checks++; if (bus.rsp0_data !== 32'hC0DE_0040) begin errors++; $display("FAIL bp_rsp0[%0d] got=%h exp=c0de0040", i, bus.rsp0_data); end
        end
        bus.rsp1_ready = 1'b1;
        #1;
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL bp_release_rdy1 got=%b exp=1", bus.req1_ready); end
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL bp_release_rdy0 got=%b exp=0", bus.req0_ready); end
        tick();
        checks++; if (bus.rsp1_valid !== 1'b1 || bus.rsp1_data !== 32'hC0DE_0034) begin errors++; $display("FAIL bp_new1 got=%b/%h exp=1/c0de0034", bus.rsp1_valid, bus.rsp1_data); end
        idle_inputs();
        tick();
    endtask

    task automatic test_errors();
        bus.req1_valid = 1'b1; bus.req1_addr = 32'h6;
        #1;
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL mis_rdy got=%b exp=1", bus.req1_ready); end
        checks++; if (bus.rom_ce !== 1'b0 || bus.rom_addr !== 32'h0) begin errors++; $display("FAIL mis_rom got=%b/%h exp=0/0", bus.rom_ce, bus.rom_addr); end
        tick();
        checks++; if (bus.rsp1_err !== 1'b1 || bus.rsp1_data !== 32'h0) begin errors++; $display("FAIL mis_rsp got=%b/%h exp=1/0", bus.rsp1_err, bus.rsp1_data); end
        bus.req1_addr = 32'h0008_0000;
        #1;
        checks++; if (bus.rom_ce !== 1'b0) begin errors++; $display("FAIL oor_ce got=%b exp=0", bus.rom_ce); end
        tick();
        checks++; if (bus.rsp1_err !== 1'b1 || bus.rsp1_data !== 32'h0) begin errors++; $display("FAIL oor_rsp got=%b/%h exp=1/0", bus.rsp1_err, bus.rsp1_data); end
        bus.req1_addr = 32'h0007_FFFC;
        #1;
        checks++; if (bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h0007_FFFC) begin errors++; $display("FAIL top_rom got=%b/%h exp=1/0007fffc", bus.rom_ce, bus.rom_addr); end
        tick();
        checks++; if (bus.rsp1_err !== 1'b0 || bus.rsp1_data !== 32'hC0DE_FFFC) begin errors++; $display("FAIL top_rsp got=%b/%h exp=0/c0defffc", bus.rsp1_err, bus.rsp1_data); end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush();
        bus.req0_valid = 1'b1; bus.req0_addr = 32'h14; bus.rsp0_ready = 1'b0;
        tick();
        checks++; if (bus.rsp0_valid !== 1'b1) begin errors++; $display("FAIL fl_full got=%b exp=1", bus.rsp0_valid); end
        bus.flush0 = 1'b1; bus.req0_addr = 32'h18;
        bus.req1_valid = 1'b1; bus.req1_addr = 32'h24;
        #1;
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL fl_rdy0 got=%b exp=0", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL fl_rdy1 got=%b exp=1", bus.req1_ready); end
        tick();
        checks++; if (bus.rsp0_valid !== 1'b0) begin errors++; $display("FAIL fl_empty got=%b exp=0", bus.rsp0_valid); end
        checks++; if (bus.rsp1_valid !== 1'b1 || bus.rsp1_data !== 32'hC0DE_0024) begin errors++; $display("FAIL fl_rsp1 got=%b/%h exp=1/c0de0024", bus.rsp1_valid, bus.rsp1_data); end
        bus.flush0 = 1'b0; bus.req1_valid = 1'b0;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL fl_after_rdy0 got=%b exp=1", bus.req0_ready); end
        tick();
        checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 32'hC0DE_0018) begin errors++; $display("FAIL fl_after_rsp0 got=%b/%h exp=1/c0de0018", bus.rsp0_valid, bus.rsp0_data); end
        idle_inputs();
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        idle_inputs();
        test_reset();
        test_contention();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
